lcd_frame_pad: RTL and testbench

- Display-side reader for the frame buffer that camera crop/write logic fills in DDR3.
- Pops an h_pixel x v_pixel frame from the DDR3 read FIFO, centres it in the LCD active area (h_disp x v_disp), and drives BORDER_COLOR outside the window.
- Sits between the DDR3 read FIFO and the LCD RGB driver.
- Issues a frame_start pulse so the DDR3 read controller restarts its read address at 0 on every frame.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_pos_cnt.sv | 43 ++++
 rtl/lcd_frame_pad.sv | 147 ++++++++++++++
 tb/tb_lcd_frame_pad.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame padder: pixel format, geometry width,
// controller state encoding.
package lcd_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 11;
  localparam logic [DATA_W-1:0] BORDER_COLOR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } lcd_state_e;

  // Leading margin when centring pix inside disp; an odd leftover goes to the trailing side.
  function automatic logic [RES_W-1:0] margin(input logic [RES_W-1:0] disp,
                                               input logic [RES_W-1:0] pix);
    logic [RES_W-1:0] diff;
    diff = disp - pix;
    return diff >> 1;
  endfunction

endpackage

// File: rtl/lcd_pos_cnt.sv
// Raster position tracker: edge-detects lcd_vs/lcd_de and keeps the x/y pixel counters.
module lcd_pos_cnt
  import lcd_pkg::*;
(
  input  logic             lcd_pclk,
  input  logic             rst_n,
  input  logic             lcd_vs,
  input  logic             lcd_de,
  output logic             vs_rise,
  output logic             de_fall,
  output logic [RES_W-1:0] x_cnt,
  output logic [RES_W-1:0] y_cnt
);

  logic lcd_vs_d1;
  logic lcd_de_d1;

  assign vs_rise = lcd_vs & ~lcd_vs_d1;
  assign de_fall = ~lcd_de & lcd_de_d1;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_vs_d1 <= 1'b0;
      lcd_de_d1 <= 1'b0;
      x_cnt     <= '0;
      y_cnt     <= '0;
    end else begin
      lcd_vs_d1 <= lcd_vs;
      lcd_de_d1 <= lcd_de;

      if (vs_rise || de_fall)
        x_cnt <= '0;
      else if (lcd_de)
        x_cnt <= x_cnt + RES_W'(1);

      if (vs_rise)
        y_cnt <= '0;
      else if (de_fall)
        y_cnt <= y_cnt + RES_W'(1);
    end
  end

endmodule

// File: rtl/lcd_frame_pad.sv
// Centres a stored h_pixel x v_pixel frame from the DDR3 read FIFO inside the LCD active
// area, padding with BORDER_COLOR, and requests a read-address restart on every frame.
//
//   state  | meaning
//   IDLE   | after reset, waiting for the first frame sync; border only
//   ACTIVE | geometry valid; pop FIFO for pixels inside the window
//   ERR    | geometry invalid for this frame; border only, config_err high
module lcd_frame_pad #(
  parameter int                  DATA_W       = lcd_pkg::DATA_W,
  parameter logic [DATA_W-1:0]   BORDER_COLOR = lcd_pkg::BORDER_COLOR
) (
  input  logic                       lcd_pclk,
  input  logic                       rst_n,
  input  logic [lcd_pkg::RES_W-1:0]  h_disp,
  input  logic [lcd_pkg::RES_W-1:0]  v_disp,
  input  logic [lcd_pkg::RES_W-1:0]  h_pixel,
  input  logic [lcd_pkg::RES_W-1:0]  v_pixel,
  input  logic                       lcd_vs,
  input  logic                       lcd_de,
  input  logic                       rd_fifo_empty,
  input  logic [DATA_W-1:0]          rd_fifo_data,
  output logic                       rd_fifo_rd_en,
  output logic                       frame_start,
  output logic                       lcd_de_o,
  output logic                       lcd_vs_o,
  output logic [DATA_W-1:0]          lcd_data,
  output logic                       config_err,
  output logic [15:0]                underflow_cnt
);

  import lcd_pkg::RES_W;
  import lcd_pkg::lcd_state_e;
  import lcd_pkg::IDLE;
  import lcd_pkg::ACTIVE;
  import lcd_pkg::ERR;
  import lcd_pkg::margin;

  logic             vs_rise;
  logic             de_fall;
  logic [RES_W-1:0] x_cnt;
  logic [RES_W-1:0] y_cnt;

  lcd_pos_cnt u_pos_cnt (
    .lcd_pclk (lcd_pclk),
    .rst_n    (rst_n),
    .lcd_vs   (lcd_vs),
    .lcd_de   (lcd_de),
    .vs_rise  (vs_rise),
    .de_fall  (de_fall),
    .x_cnt    (x_cnt),
    .y_cnt    (y_cnt)
  );

  logic [RES_W-1:0] sh_h_disp, sh_v_disp, sh_h_pixel, sh_v_pixel;
  logic [RES_W-1:0] left, right, top, bottom;
  logic             geom_ok;
  logic             in_win;
  logic             underflow;
  lcd_state_e       state, state_nxt;

  logic de_s1, vs_s1, pop_s1, win_s1;

  // Validity is judged on the raw inputs so a wrapped subtraction can never look valid.
  assign geom_ok = (h_pixel <= h_disp) && (v_pixel <= v_disp) &&
                   (h_pixel != '0) && (v_pixel != '0);

  assign left   = margin(sh_h_disp, sh_h_pixel);
  assign right  = left + sh_h_pixel;
  assign top    = margin(sh_v_disp, sh_v_pixel);
  assign bottom = top + sh_v_pixel;

  assign in_win = (x_cnt >= left) && (x_cnt < right) &&
                  (y_cnt >= top)  && (y_cnt < bottom);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      sh_h_disp  <= '0;
      sh_v_disp  <= '0;
      sh_h_pixel <= '0;
      sh_v_pixel <= '0;
    end else if (vs_rise) begin
      sh_h_disp  <= h_disp;
      sh_v_disp  <= v_disp;
      sh_h_pixel <= h_pixel;
      sh_v_pixel <= v_pixel;
    end
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    rd_fifo_rd_en = 1'b0;
    underflow     = 1'b0;
    config_err    = 1'b0;
    case (state)
      IDLE: ;
      ACTIVE: begin
        rd_fifo_rd_en = lcd_de & in_win & ~rd_fifo_empty;
        underflow     = lcd_de & in_win & rd_fifo_empty;
      end
      ERR: config_err = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // A frame sync restarts the frame from any state, including mid-frame.
    if (vs_rise)
      state_nxt = geom_ok ? ACTIVE : ERR;
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start   <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      frame_start <= vs_rise;
      if (underflow && (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

  // FIFO data arrives one cycle after the pop, so it is captured at stage 2.
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      pop_s1   <= 1'b0;
      win_s1   <= 1'b0;
      lcd_de_o <= 1'b0;
      lcd_vs_o <= 1'b0;
      lcd_data <= BORDER_COLOR;
    end else begin
      de_s1    <= lcd_de;
      vs_s1    <= lcd_vs;
      pop_s1   <= rd_fifo_rd_en;
      win_s1   <= (state == ACTIVE) & in_win;
      lcd_de_o <= de_s1;
      lcd_vs_o <= vs_s1;
      lcd_data <= (pop_s1 && win_s1) ? rd_fifo_data : BORDER_COLOR;
    end
  end

endmodule

// File: tb/tb_lcd_frame_pad.sv
// Self-checking bench for lcd_frame_pad: geometry table plus underflow, restart and reset
// sequences, with a reference model feeding an expected-output queue.
module tb_lcd_frame_pad;

  localparam logic [15:0] BORDER = 16'h0000;
  localparam int S_IDLE = 0, S_ACT = 1, S_ERR = 2;

  logic        lcd_pclk = 1'b0;
  logic        rst_n;
  logic [10:0] h_disp, v_disp, h_pixel, v_pixel;
  logic        lcd_vs, lcd_de, rd_fifo_empty;
  logic [15:0] rd_fifo_data;
  logic        rd_fifo_rd_en, frame_start, lcd_de_o, lcd_vs_o, config_err;
  logic [15:0] lcd_data, underflow_cnt;

  always #5 lcd_pclk = ~lcd_pclk;

  lcd_frame_pad dut (
    .lcd_pclk      (lcd_pclk),
    .rst_n         (rst_n),
    .h_disp        (h_disp),
    .v_disp        (v_disp),
    .h_pixel       (h_pixel),
    .v_pixel       (v_pixel),
    .lcd_vs        (lcd_vs),
    .lcd_de        (lcd_de),
    .rd_fifo_empty (rd_fifo_empty),
    .rd_fifo_data  (rd_fifo_data),
    .rd_fifo_rd_en (rd_fifo_rd_en),
    .frame_start   (frame_start),
    .lcd_de_o      (lcd_de_o),
    .lcd_vs_o      (lcd_vs_o),
    .lcd_data      (lcd_data),
    .config_err    (config_err),
    .underflow_cnt (underflow_cnt)
  );

  // FIFO stand-in: every pop presents the next sequence number one cycle later.
  logic [15:0] fifo_seq = 16'd0;
  initial rd_fifo_data = 16'hDEAD;
  always @(posedge lcd_pclk)
    if (rd_fifo_rd_en) begin
      fifo_seq     <= fifo_seq + 16'd1;
      rd_fifo_data <= fifo_seq + 16'd1;
    end

  typedef struct { logic de; logic vs; logic [15:0] data; } out_t;
  out_t exp_q[$];

  int n_cmp = 0, n_bad = 0;

  // reference model state
  int   m_st, m_x, m_y, m_l, m_r, m_t, m_b, m_pops, m_uf;
  logic m_fs, m_vs_d1, m_de_d1, m_last_erd;

  // per-frame statistics taken from the DUT
  int st_pops, st_fs, st_x0, st_x1, st_y0, st_y1, cur_x, cur_y;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_x = 0; m_y = 0; m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_uf = 0;
    m_fs = 1'b0; m_vs_d1 = 1'b0; m_de_d1 = 1'b0; m_last_erd = 1'b0;
    exp_q.delete();
    exp_q.push_back('{1'b0, 1'b0, BORDER});
    exp_q.push_back('{1'b0, 1'b0, BORDER});
  endtask

  task automatic clr_stats();
    st_pops = 0; st_fs = 0; st_x0 = 99999; st_x1 = -1; st_y0 = 99999; st_y1 = -1;
  endtask

  task automatic cyc(input logic vs, input logic de, input logic empty);
    logic vsr, dfl, inw, erd, ok;
    int   hd, vd, hp, vp;
    out_t o;
    @(negedge lcd_pclk);
    lcd_vs = vs; lcd_de = de; rd_fifo_empty = empty;
    #1;
    vsr = vs & ~m_vs_d1;
    dfl = ~de & m_de_d1;
    inw = (m_x >= m_l) && (m_x < m_r) && (m_y >= m_t) && (m_y < m_b);
    erd = (m_st == S_ACT) && de && inw && !empty;
    chk("rd_en", rd_fifo_rd_en, erd);
    chk("frame_start", frame_start, m_fs);
    chk("config_err", config_err, m_st == S_ERR);
    chk("underflow_cnt", underflow_cnt, m_uf[15:0]);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL exp_queue: got empty want entry");
    end else begin
      o = exp_q.pop_front();
      chk("lcd_de_o", lcd_de_o, o.de);
      chk("lcd_vs_o", lcd_vs_o, o.vs);
      chk("lcd_data", lcd_data, o.data);
    end
    if (erd) m_pops++;
    exp_q.push_back('{de, vs, erd ? m_pops[15:0] : BORDER});
    m_last_erd = erd;
    if (rd_fifo_rd_en) begin
      st_pops++;
      if (cur_x < st_x0) st_x0 = cur_x;
      if (cur_x > st_x1) st_x1 = cur_x;
      if (cur_y < st_y0) st_y0 = cur_y;
      if (cur_y > st_y1) st_y1 = cur_y;
    end
    if (frame_start) st_fs++;
    if ((m_st == S_ACT) && de && inw && empty && (m_uf != 65535)) m_uf++;
    m_fs = vsr;
    if (vsr) begin
      hd = int'(h_disp); vd = int'(v_disp); hp = int'(h_pixel); vp = int'(v_pixel);
      ok = (hp <= hd) && (vp <= vd) && (hp != 0) && (vp != 0);
      m_st = ok ? S_ACT : S_ERR;
      m_l = (hd - hp) / 2; m_r = m_l + hp;
      m_t = (vd - vp) / 2; m_b = m_t + vp;
    end
    if (vsr || dfl) m_x = 0; else if (de) m_x++;
    if (vsr) m_y = 0; else if (dfl) m_y++;
    m_vs_d1 = vs; m_de_d1 = de;
  endtask

  task automatic run_frame(input int hd, input int vd, input int hp, input int vp,
                           input int lines, input int uf_row, input int uf_x0, input int uf_n);
    h_disp = 11'(hd); v_disp = 11'(vd); h_pixel = 11'(hp); v_pixel = 11'(vp);
    clr_stats();
    cur_x = -1; cur_y = -1;
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < hd; x++) begin
        cur_x = x; cur_y = y;
        cyc(1'b0, 1'b1, (y == uf_row) && (x >= uf_x0) && (x < uf_x0 + uf_n));
      end
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  typedef struct { int hd, vd, hp, vp, lines, err, pops, x0, x1, y0, y1; } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{800, 480,  640, 480, 2, 0, 1280,  80, 719, 0, 1};
    tbl[1]  = '{800, 480,  631, 479, 2, 0, 1262,  84, 714, 0, 1};
    tbl[2]  = '{ 10,   7,    5,   6, 7, 0,   30,   2,   6, 0, 5};
    tbl[3]  = '{ 16,   9,    7,   4, 9, 0,   28,   4,  10, 2, 5};
    tbl[4]  = '{640, 480,  640, 480, 2, 0, 1280,   0, 639, 0, 1};
    tbl[5]  = '{  8,   4,    8,   4, 4, 0,   32,   0,   7, 0, 3};
    tbl[6]  = '{800, 480, 1024, 480, 2, 1,    0,   0,   0, 0, 0};
    tbl[7]  = '{ 16,   9,    7,   0, 9, 1,    0,   0,   0, 0, 0};
    tbl[8]  = '{ 16,   9,    0,   4, 9, 1,    0,   0,   0, 0, 0};
    tbl[9]  = '{ 16,   9,    7,  10, 9, 1,    0,   0,   0, 0, 0};
    tbl[10] = '{ 16,   9,    7,   4, 9, 0,   28,   4,  10, 2, 5};

    rst_n = 1'b0; lcd_vs = 1'b0; lcd_de = 1'b0; rd_fifo_empty = 1'b0;
    h_disp = '0; v_disp = '0; h_pixel = '0; v_pixel = '0;
    m_pops = 0; cur_x = 0; cur_y = 0;
    repeat (3) @(negedge lcd_pclk);
    #1;
    chk("rst_rd_en", rd_fifo_rd_en, 1'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_lcd_data", lcd_data, BORDER);
    chk("rst_config_err", config_err, 1'b0);
    chk("rst_underflow_cnt", underflow_cnt, 16'd0);
    @(negedge lcd_pclk);
    rst_n = 1'b1;
    model_reset();

    // no frame sync yet: lines with de must not pop
    clr_stats();
    for (int x = 0; x < 20; x++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chki("idle_pops", st_pops, 0);

    for (int i = 0; i < 11; i++) begin
      run_frame(tbl[i].hd, tbl[i].vd, tbl[i].hp, tbl[i].vp, tbl[i].lines, -1, 0, 0);
      chki($sformatf("v%0d_fs_count", i), st_fs, 1);
      chki($sformatf("v%0d_cfg_err", i), int'(config_err), tbl[i].err);
      chki($sformatf("v%0d_pops", i), st_pops, tbl[i].pops);
      if (tbl[i].pops > 0) begin
        chki($sformatf("v%0d_first_x", i), st_x0, tbl[i].x0);
        chki($sformatf("v%0d_last_x", i), st_x1, tbl[i].x1);
        chki($sformatf("v%0d_first_y", i), st_y0, tbl[i].y0);
        chki($sformatf("v%0d_last_y", i), st_y1, tbl[i].y1);
      end
    end

    // underflow: 5 empty cycles inside the window on row 3
    run_frame(16, 9, 7, 4, 9, 3, 5, 5);
    chki("uf_pops", st_pops, 23);
    chki("uf_count", int'(underflow_cnt), 5);
    run_frame(16, 9, 7, 4, 9, -1, 0, 0);
    chki("uf_next_fs", st_fs, 1);
    chki("uf_next_pops", st_pops, 28);
    chki("uf_count_hold", int'(underflow_cnt), 5);

    // restart mid-frame at row 4
    run_frame(16, 9, 7, 4, 4, -1, 0, 0);
    chki("part_pops", st_pops, 14);
    run_frame(16, 9, 7, 4, 9, -1, 0, 0);
    chki("restart_fs", st_fs, 1);
    chki("restart_pops", st_pops, 28);
    chki("restart_first_y", st_y0, 2);

    // asynchronous reset in the middle of a windowed line
    run_frame(16, 9, 7, 4, 3, -1, 0, 0);
    for (int x = 0; x < 6; x++) begin
      cur_x = x; cur_y = 3;
      cyc(1'b0, 1'b1, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", rd_fifo_rd_en, 1'b0);
    chk("mid_rst_frame_start", frame_start, 1'b0);
    chk("mid_rst_de_o", lcd_de_o, 1'b0);
    chk("mid_rst_vs_o", lcd_vs_o, 1'b0);
    chk("mid_rst_lcd_data", lcd_data, BORDER);
    chk("mid_rst_config_err", config_err, 1'b0);
    chk("mid_rst_underflow_cnt", underflow_cnt, 16'd0);
    if (m_last_erd) m_pops--;
    @(negedge lcd_pclk);
    lcd_de = 1'b0;
    @(negedge lcd_pclk);
    rst_n = 1'b1;
    model_reset();
    clr_stats();
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 16; x++) begin
        cur_x = x; cur_y = y;
        cyc(1'b0, 1'b1, 1'b0);
      end
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0);
    end
    chki("post_rst_pops", st_pops, 0);
    run_frame(16, 9, 7, 4, 9, -1, 0, 0);
    chki("post_rst_frame_pops", st_pops, 28);
    chki("post_rst_fs", st_fs, 1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
